// File: rtl/sid_pkg.sv
// Shared constants and types for the SID host-write path: protocol bit positions,
// the decoder state encoding and the layout of one queued register write.
package sid_pkg;

   localparam int         HDR_BIT   = 7;
   localparam int         ADDR_MSB  = 6;
   localparam int         ADDR_LSB  = 2;
   localparam logic [4:0] CTRL_ADDR = 5'h1F;
   localparam int         ENTRY_W   = 13;

   typedef enum logic {NOADDR, READY} dec_state_t;

   typedef struct packed {
      logic [4:0] addr;
      logic [1:0] hi;
      logic [5:0] data;
   } wr_entry_t;

endpackage

// File: rtl/sid_sync_fifo.sv
// Generic single-clock FIFO with an explicit occupancy counter and a synchronous flush.
// A push while full is accepted only when a pop happens on the same edge.
module sid_sync_fifo
   import sid_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = ENTRY_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [DATA_W-1:0]       wdata,
   output logic [DATA_W-1:0]       rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sid_write_fifo.sv
// Host two-byte write decoder feeding a FIFO that drains one SID write per clkEn tick.
// Optional SID_WFIFO_CTRL_EN turns address 0x1F into a local flush/flag-clear control register.
module sid_write_fifo
   import sid_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int GAP   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clkEn,
   input  logic [7:0]             iData,
   input  logic                   iRecv,
   output logic                   oWE,
   output logic [4:0]             oAddr,
   output logic [7:0]             oData,
   output logic [$clog2(DEPTH):0] oLevel,
   output logic                   oFull,
   output logic                   oOverflow,
   output logic                   oOrphan
);

   localparam logic [3:0] GAP_RELOAD = 4'(GAP - 1);

   dec_state_t state;
   dec_state_t state_nxt;
   logic [4:0] addr_q;
   logic [1:0] hi_q;
   logic       is_hdr;
   logic       ctrl_hit;
   logic       push;
   logic       orphan_set;
   logic       ctrl_wr;
   logic       flush;
   logic       flag_clr;
   wr_entry_t  wr_entry;
   logic [ENTRY_W-1:0] head_raw;
   wr_entry_t  head_p0;
   logic       fifo_empty;
   logic       pop_p0;
   logic [3:0] gap_cnt;

   assign is_hdr = iData[HDR_BIT];

`ifdef SID_WFIFO_CTRL_EN
   assign ctrl_hit = (addr_q == CTRL_ADDR);
`else
   assign ctrl_hit = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      push       = 1'b0;
      orphan_set = 1'b0;
      ctrl_wr    = 1'b0;
      if (iRecv) begin
         if (is_hdr)                state_nxt  = READY;
         else if (state == NOADDR)  orphan_set = 1'b1;
         else if (ctrl_hit)         ctrl_wr    = 1'b1;
         else                       push       = 1'b1;
      end
   end

   assign flush    = ctrl_wr & iData[0];
   assign flag_clr = ctrl_wr & iData[1];

   assign wr_entry.addr = addr_q;
   assign wr_entry.hi   = hi_q;
   assign wr_entry.data = iData[5:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= NOADDR;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         hi_q   <= '0;
      end else if (iRecv && is_hdr) begin
         addr_q <= iData[ADDR_MSB:ADDR_LSB];
         hi_q   <= iData[1:0];
      end
   end

   sid_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop_p0),
      .flush (flush),
      .wdata (wr_entry),
      .rdata (head_raw),
      .count (oLevel),
      .full  (oFull),
      .empty (fifo_empty)
   );

   assign head_p0 = wr_entry_t'(head_raw);

   // Stage p0: pop decision on a SID tick; a flush cancels a coinciding pop.
   assign pop_p0 = clkEn & ~fifo_empty & (gap_cnt == '0) & ~flush;

   // Stage p0 -> output: strobe and head entry are registered onto the SID bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oWE     <= 1'b0;
         oAddr   <= '0;
         oData   <= '0;
         gap_cnt <= '0;
      end else begin
         oWE <= pop_p0;
         if (pop_p0) begin
            oAddr   <= head_p0.addr;
            oData   <= {head_p0.hi, head_p0.data};
            gap_cnt <= GAP_RELOAD;
         end else if (clkEn && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oOverflow <= 1'b0;
         oOrphan   <= 1'b0;
      end else begin
         if (flag_clr) begin
            oOverflow <= 1'b0;
            oOrphan   <= 1'b0;
         end
         if (push && oFull && !pop_p0) oOverflow <= 1'b1;
         if (orphan_set)               oOrphan   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sid_write_fifo.sv
// Directed bench for sid_write_fifo: one instance with GAP=1 and one with GAP=3
// share the input stimulus; expected values are hand-computed from the byte protocol.
module tb_sid_write_fifo;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clkEn;
   logic [7:0]    iData;
   logic          iRecv;

   logic          we1, full1, ovf1, orph1;
   logic [4:0]    addr1;
   logic [7:0]    data1;
   logic [LW-1:0] level1;
   logic          we3, full3, ovf3, orph3;
   logic [4:0]    addr3;
   logic [7:0]    data3;
   logic [LW-1:0] level3;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            cyc    = 0;
   logic [12:0]   q1[$];
   logic [12:0]   q3[$];
   int            t3[$];

   sid_write_fifo #(.DEPTH(DEPTH), .GAP(1)) dut (
      .clk(clk), .rst_n(rst_n), .clkEn(clkEn), .iData(iData), .iRecv(iRecv),
      .oWE(we1), .oAddr(addr1), .oData(data1), .oLevel(level1), .oFull(full1),
      .oOverflow(ovf1), .oOrphan(orph1)
   );

   sid_write_fifo #(.DEPTH(DEPTH), .GAP(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .clkEn(clkEn), .iData(iData), .iRecv(iRecv),
      .oWE(we3), .oAddr(addr3), .oData(data3), .oLevel(level3), .oFull(full3),
      .oOverflow(ovf3), .oOrphan(orph3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Record every write strobe seen on the bus, with its cycle number for the GAP=3 unit.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (we1) q1.push_back({addr1, data1});
         if (we3) begin
            q3.push_back({addr3, data3});
            t3.push_back(cyc);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; iRecv = 1'b0; clkEn = 1'b0; iData = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      iData = b; iRecv = 1'b1;
      @(negedge clk);
      iRecv = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
   endtask

   // SID ticks spaced 12 clk apart.
   task automatic ticks(input int n);
      repeat (n) begin
         repeat (10) @(negedge clk);
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; iRecv = 1'b0; clkEn = 1'b0; iData = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_we",    32'(we1),    32'h0);
      chk("rst_addr",  32'(addr1),  32'h0);
      chk("rst_data",  32'(data1),  32'h0);
      chk("rst_level", 32'(level1), 32'h0);
      chk("rst_full",  32'(full1),  32'h0);
      chk("rst_ovf",   32'(ovf1),   32'h0);
      chk("rst_orph",  32'(orph1),  32'h0);
      chk("rst_dut3",  32'({we3, addr3, data3, level3, full3, ovf3, orph3}), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic write: 0x84 selects reg 1, hi=0; 0x15 is the data byte.
      send(8'h84);
      send(8'h15);
      chk("t1_level_push", 32'(level1), 32'd1);
      chk("t1_we_early",   32'(we1),    32'h0);
      tick();
      chk("t1_we",     32'(we1),    32'h1);
      chk("t1_addr",   32'(addr1),  32'h01);
      chk("t1_data",   32'(data1),  32'h15);
      chk("t1_level0", 32'(level1), 32'd0);
      @(negedge clk);
      chk("t1_we_width", 32'(we1),  32'h0);

      // Orphan data byte, then header 0xAB (reg 0x0A, hi=3) with data 0x3F.
      do_reset();
      send(8'h15);
      chk("t2_orphan",    32'(orph1),  32'h1);
      chk("t2_no_push",   32'(level1), 32'd0);
      send(8'hAB);
      send(8'h3F);
      tick();
      chk("t2_we",   32'(we1),   32'h1);
      chk("t2_addr", 32'(addr1), 32'h0A);
      chk("t2_data", 32'(data1), 32'hFF);

      // Burst of 20 writes with no tick: 16 kept, 4 dropped.
      do_reset();
      q1.delete();
      send(8'h84);
      for (int i = 0; i < 20; i++) send(8'(i));
      chk("t3_level", 32'(level1), 32'd16);
      chk("t3_full",  32'(full1),  32'h1);
      chk("t3_ovf",   32'(ovf1),   32'h1);
      ticks(18);
      chk("t3_count", 32'(q1.size()), 32'd16);
      if (q1.size() == 16) begin
         for (int k = 0; k < 16; k++) chk($sformatf("t3_order%0d", k), 32'(q1[k]), 32'({5'd1, 8'(k)}));
      end
      chk("t3_drained", 32'(level1), 32'd0);
      chk("t3_ovf_sticky", 32'(ovf1), 32'h1);

      // GAP=3: four writes pop every third tick, 36 clk apart.
      do_reset();
      q3.delete();
      t3.delete();
      send(8'h84);
      for (int i = 1; i <= 4; i++) send(8'(i));
      ticks(12);
      chk("t4_count", 32'(q3.size()), 32'd4);
      if (q3.size() == 4 && t3.size() == 4) begin
         for (int k = 0; k < 3; k++) chk($sformatf("t4_gap%0d", k), 32'(t3[k+1] - t3[k]), 32'd36);
         for (int k = 0; k < 4; k++) chk($sformatf("t4_data%0d", k), 32'(q3[k]), 32'({5'd1, 8'(k + 1)}));
      end

      // Full FIFO with push and pop on the same edge.
      do_reset();
      q1.delete();
      send(8'h84);
      for (int j = 0; j < 16; j++) send(8'(j));
      chk("t5_full_level", 32'(level1), 32'd16);
      @(negedge clk);
      iData = 8'h2A; iRecv = 1'b1; clkEn = 1'b1;
      @(negedge clk);
      iRecv = 1'b0; clkEn = 1'b0;
      chk("t5_level", 32'(level1), 32'd16);
      chk("t5_ovf",   32'(ovf1),   32'h0);
      chk("t5_we",    32'(we1),    32'h1);
      chk("t5_head",  32'(data1),  32'h00);
      ticks(17);
      chk("t5_count", 32'(q1.size()), 32'd17);
      if (q1.size() == 17) chk("t5_last", 32'(q1[16]), 32'({5'd1, 8'h2A}));

`ifdef SID_WFIFO_CTRL_EN
      // Control register: flush, then flag clear.
      do_reset();
      send(8'h84);
      for (int j = 0; j < 5; j++) send(8'(j));
      chk("c_level5", 32'(level1), 32'd5);
      send(8'hFC);
      send(8'h01);
      chk("c_flush", 32'(level1), 32'd0);
      q1.delete();
      ticks(4);
      chk("c_no_we", 32'(q1.size()), 32'd0);
      send(8'h84);
      for (int j = 0; j < 17; j++) send(8'(j));
      chk("c_ovf_set", 32'(ovf1), 32'h1);
      send(8'hFC);
      send(8'h02);
      chk("c_ovf_clr",  32'(ovf1),   32'h0);
      chk("c_no_flush", 32'(level1), 32'd16);
`endif

      // Reset asserted while a strobe is on the bus.
      do_reset();
      send(8'h84);
      send(8'h05);
      tick();
      chk("r_we_before", 32'(we1), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("r_we_cleared", 32'(we1),    32'h0);
      chk("r_level",      32'(level1), 32'd0);
      chk("r_addr",       32'(addr1),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h07);
      chk("r_noaddr", 32'(orph1),  32'h1);
      chk("r_nopush", 32'(level1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
